// File: rtl/ssd_scan_if.sv
// Display-side bus of the BCD counter reader: packed BCD value, decimal-point
// requests and blanking control going in, multiplexed 7-segment drive coming out.
interface ssd_scan_if;
  logic [15:0] ssd_scan_bcd;
  logic [3:0]  ssd_scan_dp;
  logic        ssd_scan_blank_lz;
  logic [3:0]  ssd_scan_an;
  logic [6:0]  ssd_scan_seg;
  logic        ssd_scan_dp_n;
  logic        ssd_scan_frame;

  // Counter side: supplies the value, observes the display pins.
  modport master (
    output ssd_scan_bcd,
    output ssd_scan_dp,
    output ssd_scan_blank_lz,
    input  ssd_scan_an,
    input  ssd_scan_seg,
    input  ssd_scan_dp_n,
    input  ssd_scan_frame
  );

  // Scanner side: reads the value, drives the display pins.
  modport slave (
    input  ssd_scan_bcd,
    input  ssd_scan_dp,
    input  ssd_scan_blank_lz,
    output ssd_scan_an,
    output ssd_scan_seg,
    output ssd_scan_dp_n,
    output ssd_scan_frame
  );
endinterface

// File: rtl/ssd_scan.sv
// Four-digit common-anode 7-segment scanner. The BCD value is frozen once per
// frame (at the end of the digit 3 window) so a frame never mixes two values.
// All display outputs are registered and therefore lag the digit index by one
// cycle; each digit is lit for exactly REFRESH_DIV cycles.
module ssd_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input logic       ssd_scan_clk,
  input logic       ssd_scan_rst,
  ssd_scan_if.slave bus
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] div_cnt_r;
  logic [CNT_W-1:0] div_cnt_nxt_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_nxt_s;
  logic             div_last_s;
  logic             snap_take_s;

  logic [15:0]      snap_r;
  logic [3:0]       snap_dp_r;
  logic             snap_lz_r;

  logic [3:0]       digit_s;
  logic             blank_s;
  logic [3:0]       an_s;
  logic [6:0]       seg_s;
  logic             dp_n_s;

  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_n_r;
  logic             frame_r;

  // State register: refresh divider and current digit index.
  always_ff @(posedge ssd_scan_clk) begin
    if (ssd_scan_rst) begin
      div_cnt_r <= DIV_ZERO;
      idx_r     <= 2'd0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
      idx_r     <= idx_nxt_s;
    end
  end

  // Next-state logic: divider wraps at REFRESH_DIV-1 and advances the digit.
  always_comb begin
    div_last_s    = (div_cnt_r == DIV_LAST);
    snap_take_s   = div_last_s && (idx_r == 2'd3);
    div_cnt_nxt_s = div_cnt_r;
    idx_nxt_s     = idx_r;
    if (div_last_s) begin
      div_cnt_nxt_s = DIV_ZERO;
      idx_nxt_s     = idx_r + 2'd1;
    end else begin
      div_cnt_nxt_s = div_cnt_r + DIV_ONE;
      idx_nxt_s     = idx_r;
    end
  end

  // Frame snapshot: reloaded at reset and on the last cycle of digit 3 only.
  always_ff @(posedge ssd_scan_clk) begin
    if (ssd_scan_rst || snap_take_s) begin
      snap_r    <= bus.ssd_scan_bcd;
      snap_dp_r <= bus.ssd_scan_dp;
      snap_lz_r <= bus.ssd_scan_blank_lz;
    end else begin
      snap_r    <= snap_r;
      snap_dp_r <= snap_dp_r;
      snap_lz_r <= snap_lz_r;
    end
  end

  // Output decode: select digit, apply leading-zero blanking, build pin values.
  always_comb begin
    digit_s = 4'h0;
    blank_s = 1'b0;
    an_s    = 4'b1111;
    seg_s   = 7'b1111111;
    dp_n_s  = 1'b1;
    case (idx_r)
      2'd0: begin
        digit_s = snap_r[3:0];
        blank_s = 1'b0;
        an_s    = 4'b1110;
      end
      2'd1: begin
        digit_s = snap_r[7:4];
        blank_s = snap_lz_r && (snap_r[15:4] == 12'h000);
        an_s    = 4'b1101;
      end
      2'd2: begin
        digit_s = snap_r[11:8];
        blank_s = snap_lz_r && (snap_r[15:8] == 8'h00);
        an_s    = 4'b1011;
      end
      2'd3: begin
        digit_s = snap_r[15:12];
        blank_s = snap_lz_r && (snap_r[15:12] == 4'h0);
        an_s    = 4'b0111;
      end
      default: begin
        digit_s = 4'h0;
        blank_s = 1'b1;
        an_s    = 4'b1111;
      end
    endcase
    if (blank_s) begin
      an_s   = 4'b1111;
      seg_s  = 7'b1111111;
      dp_n_s = 1'b1;
    end else begin
      seg_s  = seg_decode(digit_s);
      dp_n_s = ~snap_dp_r[idx_r];
    end
  end

  // Output register: all-off during reset, frame pulse follows a snapshot.
  always_ff @(posedge ssd_scan_clk) begin
    if (ssd_scan_rst) begin
      an_r    <= 4'b1111;
      seg_r   <= 7'b1111111;
      dp_n_r  <= 1'b1;
      frame_r <= 1'b0;
    end else begin
      an_r    <= an_s;
      seg_r   <= seg_s;
      dp_n_r  <= dp_n_s;
      frame_r <= snap_take_s;
    end
  end

  assign bus.ssd_scan_an    = an_r;
  assign bus.ssd_scan_seg   = seg_r;
  assign bus.ssd_scan_dp_n  = dp_n_r;
  assign bus.ssd_scan_frame = frame_r;

endmodule

// File: tb/tb_ssd_scan.sv
// Scoreboard bench for ssd_scan with REFRESH_DIV=4. The stimulus process
// pushes the hand-computed display state for each cycle; a monitor pops and
// compares on every falling edge.
module tb_ssd_scan;

  typedef struct packed {
    int         scn;
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cur_scn;
  int   cur_cyc;
  exp_t exp_q[$];

  ssd_scan_if bus_if ();

  ssd_scan #(.REFRESH_DIV(4)) dut (
    .ssd_scan_clk (clk),
    .ssd_scan_rst (rst),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push expectation for the cycle that just started (called at posedge+1).
  task automatic push_exp(input logic [3:0] an, input logic [6:0] seg,
                          input logic dp_n, input logic frame);
    exp_t e;
    e.scn   = cur_scn;
    e.cyc   = cur_cyc;
    e.an    = an;
    e.seg   = seg;
    e.dp_n  = dp_n;
    e.frame = frame;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and record what it must show.
  task automatic tick_exp(input logic [3:0] an, input logic [6:0] seg,
                          input logic dp_n, input logic frame);
    @(posedge clk);
    #1;
    cur_cyc = cur_cyc + 1;
    push_exp(an, seg, dp_n, frame);
  endtask

  // One full digit window of four cycles; frame flag applies to the last one.
  task automatic window(input logic [3:0] an, input logic [6:0] seg,
                        input logic dp_n, input logic frame_last);
    for (int i = 0; i < 3; i++) tick_exp(an, seg, dp_n, 1'b0);
    tick_exp(an, seg, dp_n, frame_last);
  endtask

  // Assert reset for one edge with the given inputs; the cycle after is cycle 0.
  task automatic do_reset(input int scn, input logic [15:0] bcd,
                          input logic [3:0] dp, input logic lz);
    rst = 1'b1;
    bus_if.ssd_scan_bcd      = bcd;
    bus_if.ssd_scan_dp       = dp;
    bus_if.ssd_scan_blank_lz = lz;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cur_scn = scn;
    cur_cyc = 0;
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
  endtask

  // Monitor: compare every recorded expectation against the pins.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (bus_if.ssd_scan_an !== e.an || bus_if.ssd_scan_seg !== e.seg ||
          bus_if.ssd_scan_dp_n !== e.dp_n || bus_if.ssd_scan_frame !== e.frame) begin
        failures = failures + 1;
        $display("FAIL scn%0d_cyc%0d: got an=%b seg=%b dp_n=%b frame=%b, expected an=%b seg=%b dp_n=%b frame=%b",
                 e.scn, e.cyc, bus_if.ssd_scan_an, bus_if.ssd_scan_seg,
                 bus_if.ssd_scan_dp_n, bus_if.ssd_scan_frame,
                 e.an, e.seg, e.dp_n, e.frame);
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cur_scn  = 0;
    cur_cyc  = 0;
    rst      = 1'b1;
    bus_if.ssd_scan_bcd      = 16'h0000;
    bus_if.ssd_scan_dp       = 4'b0000;
    bus_if.ssd_scan_blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Scan order and decode of 1234, then snapshot hold with 9876 arriving mid-frame.
    do_reset(1, 16'h1234, 4'b0000, 1'b0);
    window(4'b1110, 7'b0011001, 1'b1, 1'b0);           // cycles 1-4: '4'
    tick_exp(4'b1101, 7'b0110000, 1'b1, 1'b0);         // cycle 5: '3'
    tick_exp(4'b1101, 7'b0110000, 1'b1, 1'b0);         // cycle 6
    bus_if.ssd_scan_bcd = 16'h9876;
    tick_exp(4'b1101, 7'b0110000, 1'b1, 1'b0);         // cycle 7
    tick_exp(4'b1101, 7'b0110000, 1'b1, 1'b0);         // cycle 8
    window(4'b1011, 7'b0100100, 1'b1, 1'b0);           // cycles 9-12: '2'
    window(4'b0111, 7'b1111001, 1'b1, 1'b1);           // cycles 13-16: '1', frame at 16
    window(4'b1110, 7'b0000010, 1'b1, 1'b0);           // cycles 17-20: '6'
    window(4'b1101, 7'b1111000, 1'b1, 1'b0);           // '7'
    window(4'b1011, 7'b0000000, 1'b1, 1'b0);           // '8'
    window(4'b0111, 7'b0010000, 1'b1, 1'b1);           // cycles 29-32: '9'

    // Leading-zero blanking of 0070.
    do_reset(3, 16'h0070, 4'b0000, 1'b1);
    window(4'b1110, 7'b1000000, 1'b1, 1'b0);
    window(4'b1101, 7'b1111000, 1'b1, 1'b0);
    window(4'b1111, 7'b1111111, 1'b1, 1'b0);
    window(4'b1111, 7'b1111111, 1'b1, 1'b1);

    // Same value without blanking: all four digits lit.
    do_reset(4, 16'h0070, 4'b0000, 1'b0);
    window(4'b1110, 7'b1000000, 1'b1, 1'b0);
    window(4'b1101, 7'b1111000, 1'b1, 1'b0);
    window(4'b1011, 7'b1000000, 1'b1, 1'b0);
    window(4'b0111, 7'b1000000, 1'b1, 1'b1);

    // Invalid BCD nibble with a decimal point, upper digits blanked.
    do_reset(5, 16'h00A0, 4'b0010, 1'b1);
    window(4'b1110, 7'b1000000, 1'b1, 1'b0);
    window(4'b1101, 7'b0111111, 1'b0, 1'b0);
    window(4'b1111, 7'b1111111, 1'b1, 1'b0);
    window(4'b1111, 7'b1111111, 1'b1, 1'b1);

    // Reset mid-operation at cycle 10 with 4321.
    do_reset(6, 16'h1234, 4'b0000, 1'b0);
    window(4'b1110, 7'b0011001, 1'b1, 1'b0);           // cycles 1-4
    window(4'b1101, 7'b0110000, 1'b1, 1'b0);           // cycles 5-8
    tick_exp(4'b1011, 7'b0100100, 1'b1, 1'b0);         // cycle 9
    tick_exp(4'b1011, 7'b0100100, 1'b1, 1'b0);         // cycle 10
    do_reset(7, 16'h4321, 4'b0000, 1'b0);              // cycle 11 all-off
    window(4'b1110, 7'b1111001, 1'b1, 1'b0);           // '1'
    window(4'b1101, 7'b0100100, 1'b1, 1'b0);           // '2'
    window(4'b1011, 7'b0110000, 1'b1, 1'b0);           // '3'
    window(4'b0111, 7'b0011001, 1'b1, 1'b1);           // '4', frame 16 after release

    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
